// File: rtl/sweep_sequencer_pkg.sv
// Shared types for the AC sweep sequencer: FSM states, default widths and
// the captured solver-result record.
package sweep_pkg;

  localparam int PW_DEF = 32;
  localparam int CW_DEF = 10;
  localparam int DW_DEF = 32;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    EMIT
  } state_e;

  // Sized by the package defaults; the top narrows/widens at its ports.
  typedef struct packed {
    logic [DW_DEF-1:0] data;
    logic [CW_DEF-1:0] pidx;
    logic [CW_DEF-1:0] fidx;
    logic              last;
  } result_t;

endpackage

// File: rtl/sweep_sequencer_if.sv
// Solver launch/complete port and downstream result stream of the sweep
// sequencer; the sequencer is the master of both.
interface sweep_sequencer_if
  import sweep_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
);

  logic          sol_start;
  logic [PW-1:0] sol_param;
  logic [CW-1:0] sol_fidx;
  logic          sol_done;
  logic [DW-1:0] sol_data;

  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [CW-1:0] res_pidx;
  logic [CW-1:0] res_fidx;
  logic          res_last;

  modport master (
    output sol_start, sol_param, sol_fidx,
    input  sol_done, sol_data,
    output res_valid, res_data, res_pidx, res_fidx, res_last,
    input  res_ready
  );

  modport slave (
    input  sol_start, sol_param, sol_fidx,
    output sol_done, sol_data,
    input  res_valid, res_data, res_pidx, res_fidx, res_last,
    output res_ready
  );

endinterface

// File: rtl/sweep_index_counter.sv
// Nested parameter/frequency point counters with the parameter accumulator,
// last-point detect and zero-count detect for the sweep sequencer.
module sweep_index_counter
  import sweep_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          advance,
  input  logic [PW-1:0] cfg_p_start,
  input  logic [PW-1:0] cfg_p_step,
  input  logic [CW-1:0] cfg_p_count,
  input  logic [CW-1:0] cfg_f_count,
  output logic [CW-1:0] pidx,
  output logic [CW-1:0] fidx,
  output logic [PW-1:0] param,
  output logic          is_last,
  output logic          cfg_zero
);

  logic [PW-1:0] param_q, param_d;
  logic [PW-1:0] step_q, step_d;
  logic [CW-1:0] pidx_q, pidx_d;
  logic [CW-1:0] fidx_q, fidx_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic [CW-1:0] fcnt_q, fcnt_d;
  logic          f_wrap;

  assign f_wrap   = (fidx_q == fcnt_q - CW'(1));
  assign is_last  = (pidx_q == pcnt_q - CW'(1)) && f_wrap;
  assign cfg_zero = (cfg_p_count == '0) || (cfg_f_count == '0);

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    param_d = param_q;
    step_d  = step_q;
    pidx_d  = pidx_q;
    fidx_d  = fidx_q;
    pcnt_d  = pcnt_q;
    fcnt_d  = fcnt_q;
    if (load) begin
      param_d = cfg_p_start;
      step_d  = cfg_p_step;
      pcnt_d  = cfg_p_count;
      fcnt_d  = cfg_f_count;
      pidx_d  = '0;
      fidx_d  = '0;
    end else if (advance) begin
      if (f_wrap) begin
        fidx_d  = '0;
        pidx_d  = pidx_q + CW'(1);
        param_d = param_q + step_q;  // modulo 2^PW, wrap is silent
      end else begin
        fidx_d = fidx_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
    if (rst) begin
      param_q <= '0;
      step_q  <= '0;
      pidx_q  <= '0;
      fidx_q  <= '0;
      pcnt_q  <= '0;
      fcnt_q  <= '0;
    end else begin
      param_q <= param_d;
      step_q  <= step_d;
      pidx_q  <= pidx_d;
      fidx_q  <= fidx_d;
      pcnt_q  <= pcnt_d;
      fcnt_q  <= fcnt_d;
    end
  end

  assign pidx  = pidx_q;
  assign fidx  = fidx_q;
  assign param = param_q;

endmodule

// File: rtl/sweep_sequencer.sv
// Drives a nested parameter/frequency sweep through the AC solver, one
// evaluation at a time, and forwards each result over valid/ready.
module sweep_sequencer
  import sweep_pkg::*;
#(
  parameter int PW = PW_DEF,
  parameter int CW = CW_DEF,
  parameter int DW = DW_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      run,
  input  logic                      abort,
  input  logic [PW-1:0]             cfg_p_start,
  input  logic [PW-1:0]             cfg_p_step,
  input  logic [CW-1:0]             cfg_p_count,
  input  logic [CW-1:0]             cfg_f_count,
  output logic                      busy,
  output logic                      done,
  output logic                      aborted,
  sweep_sequencer_if.master         bus
);

  state_e        state_q, state_d;
  result_t       res_q, res_d;
  logic          sol_start_q, sol_start_d;
  logic          res_valid_q, res_valid_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          aborted_q, aborted_d;

  logic          load, advance, is_last, cfg_zero;
  logic [CW-1:0] pidx, fidx;
  logic [PW-1:0] param;

  assign load    = (state_q == IDLE) && run && !abort;
  assign advance = (state_q == EMIT) && bus.res_ready && !res_q.last && !abort;

  sweep_index_counter #(.PW(PW), .CW(CW)) u_index (
    .clk         (clk),
    .rst         (rst),
    .load        (load),
    .advance     (advance),
    .cfg_p_start (cfg_p_start),
    .cfg_p_step  (cfg_p_step),
    .cfg_p_count (cfg_p_count),
    .cfg_f_count (cfg_f_count),
    .pidx        (pidx),
    .fidx        (fidx),
    .param       (param),
    .is_last     (is_last),
    .cfg_zero    (cfg_zero)
  );

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    sol_start_d = 1'b0;
    res_valid_d = res_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    // Abort outranks a same-cycle sol_done or handshake.
    if (abort && state_q != IDLE) begin
      state_d     = IDLE;
      res_valid_d = 1'b0;
      busy_d      = 1'b0;
      aborted_d   = 1'b1;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (load) begin
            if (cfg_zero) begin
              done_d = 1'b1;
            end else begin
              state_d     = ISSUE;
              sol_start_d = 1'b1;
              busy_d      = 1'b1;
            end
          end
        end
        ISSUE: state_d = WAIT;
        WAIT: begin
          if (bus.sol_done) begin
            res_d.data  = bus.sol_data;
            res_d.pidx  = pidx;
            res_d.fidx  = fidx;
            res_d.last  = is_last;
            res_valid_d = 1'b1;
            state_d     = EMIT;
          end
        end
        EMIT: begin
          if (bus.res_ready) begin
            res_valid_d = 1'b0;
            if (res_q.last) begin
              state_d = IDLE;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d     = ISSUE;
              sol_start_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      res_q       <= '0;
      sol_start_q <= 1'b0;
      res_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      sol_start_q <= sol_start_d;
      res_valid_q <= res_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
    end
  end

  assign bus.sol_start = sol_start_q;
  assign bus.sol_param = param;
  assign bus.sol_fidx  = fidx;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = DW'(res_q.data);
  assign bus.res_pidx  = CW'(res_q.pidx);
  assign bus.res_fidx  = CW'(res_q.fidx);
  assign bus.res_last  = res_q.last;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;

endmodule

// File: tb/tb_sweep_sequencer.sv
// Bench for sweep_sequencer: table of sweep configurations run against a
// solver model and a result scoreboard, plus abort/spurious-input sequences.
module tb_sweep_sequencer;
  import sweep_pkg::*;

  typedef struct {
    logic [31:0] p_start;
    logic [31:0] p_step;
    logic [9:0]  p_count;
    logic [9:0]  f_count;
    int          lat;
    int          stall;
    int          exp_starts;
  } vec_t;

  typedef struct {
    logic [31:0] param;
    logic [9:0]  pidx;
    logic [9:0]  fidx;
    logic        last;
    logic [31:0] data;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        abort = 1'b0;
  logic [31:0] cfg_p_start = '0;
  logic [31:0] cfg_p_step = '0;
  logic [9:0]  cfg_p_count = '0;
  logic [9:0]  cfg_f_count = '0;
  logic        busy, done, aborted;

  sweep_sequencer_if #(.PW(32), .CW(10), .DW(32)) bus ();

  sweep_sequencer #(.PW(32), .CW(10), .DW(32)) u_dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .abort       (abort),
    .cfg_p_start (cfg_p_start),
    .cfg_p_step  (cfg_p_step),
    .cfg_p_count (cfg_p_count),
    .cfg_f_count (cfg_f_count),
    .busy        (busy),
    .done        (done),
    .aborted     (aborted),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  int   n_checks = 0, n_fail = 0, cyc = 0;
  exp_t issue_q[$], res_q[$], cur;
  int   sol_cnt = 0, cur_lat = 1, cur_stall = 0, stall_cnt = 0, valid_len = 0;
  logic inj_done = 1'b0, abort_on_done = 1'b0, auto_abort = 1'b0, pend = 1'b0;
  logic sweep_active = 1'b0;
  logic [31:0] held_data;
  logic [9:0]  held_pidx, held_fidx;
  logic        held_last;
  int   n_starts = 0, n_results = 0, n_done = 0, n_aborted = 0, n_valid = 0, busy_err = 0;
  int   first_start = -1, done_cyc = -1, hs_cyc = -1, abort_cyc = -1, aborted_cyc = -1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: observe DUT outputs at the falling edge, then drive the
  // solver and sink inputs for the next rising edge.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    cyc++;
    if (auto_abort) begin
      abort      = 1'b0;
      auto_abort = 1'b0;
    end
    bus.sol_done = inj_done;
    inj_done     = 1'b0;
    if (sol_cnt > 0) begin
      sol_cnt--;
      if (sol_cnt == 0) begin
        check("sol_param_hold", 64'(bus.sol_param), 64'(cur.param));
        check("sol_fidx_hold", 64'(bus.sol_fidx), 64'(cur.fidx));
        bus.sol_done = 1'b1;
        bus.sol_data = cur.data;
        if (abort_on_done) begin
          abort         = 1'b1;
          auto_abort    = 1'b1;
          abort_on_done = 1'b0;
          abort_cyc     = cyc;
        end
      end
    end
    if (bus.sol_start) begin
      n_starts++;
      if (first_start < 0) first_start = cyc;
      check("start_while_result_pending", 64'(bus.res_valid), 64'(0));
      check("start_expected", 64'(issue_q.size() != 0), 64'(1));
      if (issue_q.size() != 0) begin
        cur = issue_q.pop_front();
        check("sol_param", 64'(bus.sol_param), 64'(cur.param));
        check("sol_fidx", 64'(bus.sol_fidx), 64'(cur.fidx));
        res_q.push_back(cur);
      end
      sol_cnt = cur_lat;
    end
    if (bus.res_valid) begin
      n_valid++;
      if (pend) begin
        check("hold_data", 64'(bus.res_data), 64'(held_data));
        check("hold_pidx", 64'(bus.res_pidx), 64'(held_pidx));
        check("hold_fidx", 64'(bus.res_fidx), 64'(held_fidx));
        check("hold_last", 64'(bus.res_last), 64'(held_last));
        valid_len++;
      end else begin
        stall_cnt = cur_stall;
        valid_len = 1;
        held_data = bus.res_data;
        held_pidx = bus.res_pidx;
        held_fidx = bus.res_fidx;
        held_last = bus.res_last;
      end
      bus.res_ready = (stall_cnt == 0);
      if (stall_cnt > 0) stall_cnt--;
      if (bus.res_ready) begin
        pend   = 1'b0;
        hs_cyc = cyc;
        n_results++;
        check("valid_hold_len", 64'(valid_len), 64'(cur_stall + 1));
        check("result_expected", 64'(res_q.size() != 0), 64'(1));
        if (res_q.size() != 0) begin
          e = res_q.pop_front();
          check("res_data", 64'(bus.res_data), 64'(e.data));
          check("res_pidx", 64'(bus.res_pidx), 64'(e.pidx));
          check("res_fidx", 64'(bus.res_fidx), 64'(e.fidx));
          check("res_last", 64'(bus.res_last), 64'(e.last));
        end
      end else begin
        pend = 1'b1;
      end
    end else begin
      pend          = 1'b0;
      bus.res_ready = 1'b1;
    end
    if (done) begin
      n_done++;
      done_cyc = cyc;
    end
    if (aborted) begin
      n_aborted++;
      aborted_cyc = cyc;
    end
    if (sweep_active) begin
      if (done || aborted) begin
        sweep_active = 1'b0;
        if (busy) busy_err++;
      end else if (!busy) begin
        busy_err++;
      end
    end else if (busy) begin
      busy_err++;
    end
  endtask

  task automatic load_model(input vec_t v);
    exp_t        e;
    logic [31:0] p;
    issue_q.delete();
    res_q.delete();
    p = v.p_start;
    for (int pi = 0; pi < int'(v.p_count); pi++) begin
      for (int fi = 0; fi < int'(v.f_count); fi++) begin
        e.param = p;
        e.pidx  = 10'(pi);
        e.fidx  = 10'(fi);
        e.last  = (pi == int'(v.p_count) - 1) && (fi == int'(v.f_count) - 1);
        e.data  = 32'h5A00_0000 ^ p ^ (32'(fi) << 12) ^ (32'(pi) << 22);
        issue_q.push_back(e);
      end
      p = p + v.p_step;
    end
    cur_lat     = v.lat;
    cur_stall   = v.stall;
    first_start = -1;
    done_cyc    = -1;
    hs_cyc      = -1;
    cfg_p_start = v.p_start;
    cfg_p_step  = v.p_step;
    cfg_p_count = v.p_count;
    cfg_f_count = v.f_count;
  endtask

  task automatic run_sweep(input vec_t v, input int mid_run, input string tag);
    int s0, r0, d0, run_cyc;
    bit fin;
    s0 = n_starts; r0 = n_results; d0 = n_done; fin = 1'b0; run_cyc = cyc;
    load_model(v);
    for (int i = 0; i < 3000 && !fin; i++) begin
      run = (i == 0) || (i == mid_run);
      if (i == 0) begin
        run_cyc      = cyc;
        sweep_active = (v.exp_starts != 0);
      end
      tick();
      if (i == 0) begin
        cfg_p_start = ~v.p_start;
        cfg_p_step  = v.p_step + 32'd3;
        cfg_p_count = v.p_count + 10'd1;
        cfg_f_count = v.f_count + 10'd1;
      end
      fin = (n_done != d0);
    end
    run = 1'b0;
    check({tag, "_finished"}, 64'(fin), 64'(1));
    check({tag, "_starts"}, 64'(n_starts - s0), 64'(v.exp_starts));
    check({tag, "_results"}, 64'(n_results - r0), 64'(v.exp_starts));
    check({tag, "_issue_left"}, 64'(issue_q.size()), 64'(0));
    if (v.exp_starts > 0) begin
      check({tag, "_first_start_cycle"}, 64'(first_start), 64'(run_cyc + 1));
      check({tag, "_done_after_last_hs"}, 64'(done_cyc), 64'(hs_cyc + 1));
    end else begin
      check({tag, "_done_after_run"}, 64'(done_cyc), 64'(run_cyc + 1));
    end
    tick();
    tick();
    check({tag, "_single_done"}, 64'(n_done - d0), 64'(1));
    check({tag, "_busy_window"}, 64'(busy_err), 64'(0));
  endtask

  vec_t vecs[7];
  vec_t av;

  initial begin
    int s0, r0, d0, a0, v0;
    bus.sol_done  = 1'b0;
    bus.sol_data  = '0;
    bus.res_ready = 1'b0;

    vecs[0] = '{32'd100,        32'd50,         10'd3, 10'd2, 4, 0,  6};
    vecs[1] = '{32'hFFFF_FFF0,  32'h20,         10'd2, 10'd1, 2, 0,  2};
    vecs[2] = '{32'd5,          32'd3,          10'd0, 10'd4, 2, 0,  0};
    vecs[3] = '{32'd5,          32'd3,          10'd4, 10'd0, 2, 0,  0};
    vecs[4] = '{32'd1000,       32'd7,          10'd2, 10'd3, 1, 2,  6};
    vecs[5] = '{32'd0,          32'd1,          10'd1, 10'd1, 3, 10, 1};
    vecs[6] = '{32'h8000_0000,  32'h4000_0000,  10'd3, 10'd3, 2, 1,  9};

    rst = 1'b1;
    repeat (3) tick();
    check("rst_sol_start", 64'(bus.sol_start), 64'(0));
    check("rst_sol_param", 64'(bus.sol_param), 64'(0));
    check("rst_sol_fidx", 64'(bus.sol_fidx), 64'(0));
    check("rst_res_valid", 64'(bus.res_valid), 64'(0));
    check("rst_res_data", 64'(bus.res_data), 64'(0));
    check("rst_res_idx", 64'({bus.res_pidx, bus.res_fidx, bus.res_last}), 64'(0));
    check("rst_status", 64'({busy, done, aborted}), 64'(0));
    rst = 1'b0;
    tick();

    for (int k = 0; k < 7; k++) run_sweep(vecs[k], -1, $sformatf("vec%0d", k));

    // abort landing on the same edge as sol_done
    av = '{32'd10, 32'd1, 10'd2, 10'd2, 3, 0, 4};
    load_model(av);
    s0 = n_starts; r0 = n_results; d0 = n_done; a0 = n_aborted; v0 = n_valid;
    abort_on_done = 1'b1;
    run = 1'b1;
    sweep_active = 1'b1;
    tick();
    run = 1'b0;
    for (int i = 0; i < 200 && n_aborted == a0; i++) tick();
    check("abort_latency", 64'(aborted_cyc), 64'(abort_cyc + 1));
    repeat (6) tick();
    check("abort_single_pulse", 64'(n_aborted - a0), 64'(1));
    check("abort_no_valid", 64'(n_valid - v0), 64'(0));
    check("abort_no_done", 64'(n_done - d0), 64'(0));
    check("abort_one_start", 64'(n_starts - s0), 64'(1));
    check("abort_no_results", 64'(n_results - r0), 64'(0));
    check("abort_busy_window", 64'(busy_err), 64'(0));
    abort_on_done = 1'b0;
    sol_cnt = 0;
    run_sweep(vecs[0], -1, "restart");

    // abort alone, and abort with run, while idle
    load_model(vecs[0]);
    s0 = n_starts; d0 = n_done; a0 = n_aborted;
    abort = 1'b1;
    tick();
    run = 1'b1;
    tick();
    abort = 1'b0;
    run = 1'b0;
    repeat (5) tick();
    check("idle_abort_no_start", 64'(n_starts - s0), 64'(0));
    check("idle_abort_no_done", 64'(n_done - d0), 64'(0));
    check("idle_abort_no_pulse", 64'(n_aborted - a0), 64'(0));
    check("idle_abort_busy", 64'(busy_err), 64'(0));

    // spurious sol_done while idle, then a run pulse in the middle of a sweep
    s0 = n_starts; v0 = n_valid;
    inj_done = 1'b1;
    repeat (4) tick();
    check("spurious_done_no_start", 64'(n_starts - s0), 64'(0));
    check("spurious_done_no_valid", 64'(n_valid - v0), 64'(0));
    run_sweep(vecs[0], 8, "midrun");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/sweep_sequencer.md
Name: sweep_sequencer

Overview:
Sequences a nested parameter/frequency sweep for the AC small-signal solver: outer loop steps a component parameter (e.g. R_par), inner loop steps the frequency-point index.
For each point it launches one solver evaluation, waits for completion, and forwards the result to a downstream sink over a valid/ready handshake.
Sits between the simulation control register block and the AC solver datapath; it is the only master of the solver start/done interface.

Parameters:
PW, 32, parameter value width (unsigned fixed point; interpretation owned by solver)
CW, 10, width of outer (parameter) and inner (frequency) point counters
DW, 32, solver result width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
run  in  1  start pulse; sampled only in IDLE
abort  in  1  terminate sweep; any state
cfg_p_start  in  PW  first parameter value
cfg_p_step  in  PW  parameter increment
cfg_p_count  in  CW  number of parameter points
cfg_f_count  in  CW  frequency points per parameter value
sol_start  out  1  one-cycle evaluation launch
sol_param  out  PW  parameter value for current evaluation
sol_fidx  out  CW  frequency index for current evaluation
sol_done  in  1  evaluation complete pulse
sol_data  in  DW  result, valid with sol_done
res_valid  out  1  result available
res_ready  in  1  sink accepts
res_data  out  DW  captured result
res_pidx  out  CW  parameter index of result
res_fidx  out  CW  frequency index of result
res_last  out  1  final result of sweep
busy  out  1  high from cycle after accepted run until sweep ends
done  out  1  one-cycle pulse on normal completion
aborted  out  1  one-cycle pulse when abort terminates an active sweep

Behaviour:
- Reset: state IDLE; all outputs 0; counters, sol_param and captured data 0.
- States: IDLE, ISSUE, WAIT, EMIT.
- IDLE: on run, latch all cfg_* (cfg changes mid-sweep are ignored); pidx=fidx=0; sol_param=cfg_p_start.
  - If either count is 0: done pulses next cycle; busy stays 0; no sol_start.
  - Otherwise go to ISSUE.
- ISSUE: sol_start=1 for exactly one cycle. The first sol_start is the cycle after run. Go to WAIT.
- WAIT: hold sol_param/sol_fidx stable. On sol_done, capture sol_data and indices, then go to EMIT. res_valid rises the following cycle.
- EMIT: res_valid held, with res_data/res_pidx/res_fidx/res_last stable, until res_valid&&res_ready.
  - res_last=1 iff pidx==p_count-1 and fidx==f_count-1.
  - On handshake, if not last: advance indices and go to ISSUE. The next sol_start is the cycle after the handshake.
  - On handshake, if last: go to IDLE; done pulses and busy falls the cycle after the handshake.
- Index advance: fidx+1; on fidx==f_count-1, fidx=0, pidx+1, and sol_param += p_step. The addition is modulo 2^PW; wrap is silent and not flagged.
- Throughput: minimum 3 cycles per point plus solver latency; no overlap of evaluations.
- sol_done outside WAIT: ignored.
- run while busy: ignored.
- abort in any non-IDLE state: next cycle go to IDLE; res_valid, busy and sol_start are 0; aborted pulses; done does not pulse.
  - abort has priority over a same-cycle sol_done or handshake.
  - abort in IDLE: no effect.
- abort and run in the same IDLE cycle: abort wins; run is dropped.
- rst mid-sweep: immediate return to reset values; no done or aborted pulse.

Decomposition:
- Shared package sweep_pkg: state enum (IDLE/ISSUE/WAIT/EMIT), default widths PW/CW/DW, and a result struct {data, pidx, fidx, last}.
- One natural sub-module, sweep_index_counter: nested pidx/fidx counters with parameter accumulator, last-point detect and zero-count detect.
- The FSM, result capture and handshake stay in the top level.

Test Plan:
- p_start=100, p_step=50, p_count=3, f_count=2, solver 4-cycle latency, res_ready=1 -> exactly 6 sol_start. sol_param sequence 100,100,150,150,200,200; sol_fidx 0,1,0,1,0,1. res_last only on the 6th result; done 1 cycle after the 6th handshake.
- p_count=0 or f_count=0 with run -> done pulses next cycle; no sol_start, no res_valid, busy never high.
- res_ready held low 10 cycles in EMIT -> res_valid and res_data stable for 10 cycles; no new sol_start until the handshake.
- abort asserted during WAIT, coincident with sol_done -> aborted pulses, res_valid stays 0, done stays 0, next run restarts from index 0.
- p_start=0xFFFFFFF0, p_step=0x20, p_count=2, f_count=1 -> second sol_param=0x00000010 (wrap); sweep completes normally.
- Spurious sol_done in IDLE and run pulsed mid-sweep -> no state change, no extra evaluations, result count unchanged.
